// File: rtl/wavelet_pkg.sv
// Shared constants for the sym4 wavelet stages: datapath widths, the
// growth used by the MAC adder tree and the sym4 filter banks at Q1.23.
package wavelet_pkg;

    localparam int INTERNAL_WIDTH_DEF = 48;
    localparam int COEF_WIDTH_DEF     = 25;
    localparam int COEF_FRAC_DEF      = 23;

    // Guard bits added by the two adder levels behind the products
    localparam int PART_GROW = 2;
    localparam int SUM_GROW  = 3;

    // Warm-up counter value at which the window holds four real pairs
    localparam logic [1:0] WARM_FULL = 2'd3;

    // Full-precision product width
    function automatic int mult_width(input int iw, input int cw);
        return iw + cw;
    endfunction

    // Output slice taken from the final sum: [frac+iw-1 : frac]
    function automatic int trunc_msb(input int iw, input int frac);
        return frac + iw - 1;
    endfunction

    function automatic int trunc_lsb(input int frac);
        return frac;
    endfunction

    // sym4 decomposition / reconstruction banks, scaled by 2^23 and rounded
    localparam logic signed [24:0] SYM4_DEC_LO [8] = '{
        -25'sd635569, -25'sd248601, 25'sd4174328, 25'sd6742249,
         25'sd2498612, -25'sd832314, -25'sd105730, 25'sd270307};
    localparam logic signed [24:0] SYM4_DEC_HI [8] = '{
        -25'sd270307, -25'sd105730, 25'sd832314, 25'sd2498612,
        -25'sd6742249, 25'sd4174328, 25'sd248601, -25'sd635569};
    localparam logic signed [24:0] SYM4_REC_LO [8] = '{
         25'sd270307, -25'sd105730, -25'sd832314, 25'sd2498612,
         25'sd6742249, 25'sd4174328, -25'sd248601, -25'sd635569};
    localparam logic signed [24:0] SYM4_REC_HI [8] = '{
        -25'sd635569, 25'sd248601, 25'sd4174328, -25'sd6742249,
         25'sd2498612, 25'sd832314, -25'sd105730, -25'sd270307};

endpackage

// File: rtl/fir8_mac.sv
// Eight-tap constant-coefficient MAC: registered products, registered
// 4-term partial sums, then a registered truncated final sum.
// Pure datapath; qualification is handled by the caller.
module fir8_mac #(
    parameter int IW   = 48,
    parameter int CW   = 25,
    parameter int FRAC = 23,
    parameter logic [7:0][CW-1:0] TAPS = {(8*CW){1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0][IW-1:0]   x,
    output logic signed [IW-1:0] y
);
    import wavelet_pkg::*;

    localparam int MW = mult_width(IW, CW);
    localparam int PW = MW + PART_GROW;

    logic signed [MW-1:0] op_s   [8];
    logic signed [MW-1:0] tap_s  [8];
    logic signed [MW-1:0] prod_r [8];
    logic signed [PW-1:0] part_s [2];
    logic signed [PW-1:0] part_r [2];

    // Sign-extend operands and taps to full product width
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            op_s[k]  = $signed({{CW{x[k][IW-1]}}, x[k]});
            tap_s[k] = $signed({{IW{TAPS[k][CW-1]}}, TAPS[k]});
        end
    end

    // Stage 1: full-precision products
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            prod_r[k] <= op_s[k] * tap_s[k];
        end
    end

    // Two 4-term partial sums with guard bits against overflow
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            part_s[g] = {PW{1'b0}};
            for (int k = 0; k < 4; k++) begin
                part_s[g] = part_s[g]
                    + $signed({{PART_GROW{prod_r[4*g+k][MW-1]}}, prod_r[4*g+k]});
            end
        end
    end

    // Stage 2: register the partial sums
    always_ff @(posedge clk) begin
        part_r[0] <= part_s[0];
        part_r[1] <= part_s[1];
    end

    // Stage 3: final sum, arithmetic shift drops the fraction (floor), wrap to IW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= {IW{1'b0}};
        end else begin
            y <= IW'(($signed({part_r[0][PW-1], part_r[0]})
                    + $signed({part_r[1][PW-1], part_r[1]})) >>> trunc_lsb(FRAC));
        end
    end

endmodule

// File: rtl/decompose_l4.sv
// Level-4 sym4 analysis stage: one pair in, one (a4, d4) pair out, with
// a three-pair history window, warm-up gating and a 3-deep valid pipe.
module decompose_l4 #(
    parameter int INTERNAL_WIDTH = 48,
    parameter int COEF_WIDTH     = 25,
    parameter int COEF_FRAC      = 23,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO0 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO1 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO2 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO3 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO4 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO5 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO6 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO7 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI0 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI1 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI2 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI3 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI4 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI5 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI6 = {COEF_WIDTH{1'b0}},
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI7 = {COEF_WIDTH{1'b0}}
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             din_valid,
    input  logic signed [INTERNAL_WIDTH-1:0] x_0,
    input  logic signed [INTERNAL_WIDTH-1:0] x_1,
    output logic                             dout_valid,
    output logic signed [INTERNAL_WIDTH-1:0] a4_out,
    output logic signed [INTERNAL_WIDTH-1:0] d4_out
);
    import wavelet_pkg::*;

    localparam int IW = INTERNAL_WIDTH;

    localparam logic [7:0][COEF_WIDTH-1:0] LO_TAPS =
        {DEC_LO7, DEC_LO6, DEC_LO5, DEC_LO4, DEC_LO3, DEC_LO2, DEC_LO1, DEC_LO0};
    localparam logic [7:0][COEF_WIDTH-1:0] HI_TAPS =
        {DEC_HI7, DEC_HI6, DEC_HI5, DEC_HI4, DEC_HI3, DEC_HI2, DEC_HI1, DEC_HI0};

    // hist_r[0] = previous odd sample, hist_r[1] = previous even sample, ...
    logic [5:0][IW-1:0] hist_r;
    logic [1:0]         warm_r;
    logic               v1_r;
    logic               v2_r;
    logic               warm_full_s;
    logic [7:0][IW-1:0] win_s;

    assign warm_full_s = (warm_r == WARM_FULL);

    // Window entry k is s[2n+1-k]: current odd, current even, then history
    assign win_s = {hist_r, x_0, x_1};

    // History, warm-up counter and valid pipeline; clr outranks din_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r     <= {(6*IW){1'b0}};
            warm_r     <= 2'd0;
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            hist_r     <= {(6*IW){1'b0}};
            warm_r     <= 2'd0;
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            if (din_valid) begin
                hist_r <= {hist_r[3:0], x_0, x_1};
                if (!warm_full_s) begin
                    warm_r <= warm_r + 2'd1;
                end
            end
            // Only pairs accepted with a full history produce output
            v1_r       <= din_valid & warm_full_s;
            v2_r       <= v1_r;
            dout_valid <= v2_r;
        end
    end

    fir8_mac #(
        .IW   (IW),
        .CW   (COEF_WIDTH),
        .FRAC (COEF_FRAC),
        .TAPS (LO_TAPS)
    ) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (win_s),
        .y     (a4_out)
    );

    fir8_mac #(
        .IW   (IW),
        .CW   (COEF_WIDTH),
        .FRAC (COEF_FRAC),
        .TAPS (HI_TAPS)
    ) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (win_s),
        .y     (d4_out)
    );

endmodule
